umtrx_rx_mux: RTL

UMTRX_RX_MUX -- requirements
Module: umtrx_rx_mux

---
 rtl/umtrx_rx_pkg.sv | 18 +
 rtl/umtrx_rr_arbiter.sv | 29 ++
 rtl/umtrx_rx_mux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/umtrx_rx_pkg.sv
// Shared constants for the UmTRX RX stream mux: beat field positions,
// FSM encoding and settings-register offsets.
package umtrx_rx_pkg;

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int OCC_LO  = 34;
  localparam int OCC_HI  = 35;

  localparam int REG_MASK_OFS = 0;
  localparam int REG_CLR_OFS  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/umtrx_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after i_last,
// wrapping modulo NUM_CHAN.
module umtrx_rr_arbiter #(
  parameter int NUM_CHAN = 2,
  parameter int IDX_W    = 1
) (
  input  logic [NUM_CHAN-1:0] i_req,
  input  logic [IDX_W-1:0]    i_last,
  output logic [IDX_W-1:0]    o_grant,
  output logic                o_any
);

  int w_c;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_c     = 0;
    for (int k = NUM_CHAN; k >= 1; k--) begin
      w_c = (int'(i_last) + k) % NUM_CHAN;
      if (i_req[w_c]) begin
        o_grant = IDX_W'(w_c);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/umtrx_rx_mux.sv
// Packet-atomic round-robin merge of NUM_CHAN VITA RX streams onto one port.
// Optional per-channel EOF counters are built when UMTRX_RX_MUX_STATS_EN is defined.
module umtrx_rx_mux
  import umtrx_rx_pkg::*;
#(
  parameter int NUM_CHAN = 2,
  parameter int BASE     = 0,
  parameter int WIDTH    = 36
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [NUM_CHAN*WIDTH-1:0] i_tdata,
  input  logic [NUM_CHAN-1:0]       i_tvalid,
  output logic [NUM_CHAN-1:0]       i_tready,
  output logic [WIDTH-1:0]          o_tdata,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  input  logic [2:0]                stat_sel,
  output logic [31:0]               stat_count
);

  localparam int         IDX_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [7:0] A_MASK = 8'(BASE + REG_MASK_OFS);

  state_t              r_state, w_next;
  logic [IDX_W-1:0]    r_sel, r_last, w_grant;
  logic [NUM_CHAN-1:0] r_mask, w_req;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_any, w_sel_valid, w_xfer, w_eof, w_mask_wr;
  logic                w_unused_data;

  assign w_req         = r_mask & i_tvalid;
  assign w_mask_wr     = set_stb && (set_addr == A_MASK);
  assign w_unused_data = ^set_data[31:NUM_CHAN];

  umtrx_rr_arbiter #(
    .NUM_CHAN (NUM_CHAN),
    .IDX_W    (IDX_W)
  ) u_arb (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int n = 0; n < NUM_CHAN; n++) begin
      if (r_sel == IDX_W'(n)) begin
        w_sel_data  = i_tdata[n*WIDTH +: WIDTH];
        w_sel_valid = i_tvalid[n];
      end
    end
  end

  assign w_xfer = (r_state == ST_GRANT) && w_sel_valid && o_tready;
  assign w_eof  = w_xfer && w_sel_data[EOF_BIT];

  // The mask only feeds the IDLE arbitration, so a packet in flight is never cut.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= IDX_W'(NUM_CHAN - 1);
      r_mask  <= '1;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_any) r_sel <= w_grant;
      if (w_eof) r_last <= r_sel;
      if (w_mask_wr) r_mask <= set_data[NUM_CHAN-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_GRANT;
      ST_GRANT: if (w_eof) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tvalid = 1'b0;
    o_tdata  = '0;
    i_tready = '0;
    if (r_state == ST_GRANT) begin
      o_tvalid = w_sel_valid;
      o_tdata  = w_sel_data;
      for (int n = 0; n < NUM_CHAN; n++) begin
        if (r_sel == IDX_W'(n)) i_tready[n] = o_tready;
      end
    end
  end

`ifdef UMTRX_RX_MUX_STATS_EN
  localparam logic [7:0] A_CLR = 8'(BASE + REG_CLR_OFS);

  logic [31:0] r_cnt [NUM_CHAN];
  logic        w_clr;

  assign w_clr = set_stb && (set_addr == A_CLR);

  // Clear has priority over a coinciding EOF increment.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CHAN; n++) begin
      if (rst || w_clr) r_cnt[n] <= '0;
      else if (w_eof && (r_sel == IDX_W'(n))) r_cnt[n] <= r_cnt[n] + 32'd1;
    end
  end

  always_comb begin
    stat_count = '0;
    for (int n = 0; n < NUM_CHAN; n++) begin
      if (stat_sel == 3'(n)) stat_count = r_cnt[n];
    end
  end
`else
  logic w_unused_stat;
  assign w_unused_stat = ^stat_sel;
  assign stat_count    = '0;
`endif

endmodule
